// File: rtl/mem_bus_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : mem_bus_arbiter
//  Description : Round-robin arbiter sharing the memory/MMU data-bus port
//                between the CPU core (master 0) and a secondary requester
//                (master 1). One transaction in flight at a time; the winning
//                request is registered onto the slave side. A watchdog aborts
//                transactions the slave never acknowledges.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_bus_arbiter #(
    parameter int TIMEOUT = 255,  // slave cycles allowed per transaction; 0 disables watchdog
    parameter int CNT_W   = 8     // watchdog counter width, 2**CNT_W > TIMEOUT
) (
    input  logic        clk,
    input  logic        res,

    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_dataOut,
    input  logic [1:0]  m0_accessType,
    input  logic [1:0]  m0_memLen,
    input  logic        m0_signed,
    output logic [31:0] m0_dataIn,
    output logic        m0_ready,
    output logic        m0_err,

    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_dataOut,
    input  logic [1:0]  m1_accessType,
    input  logic [1:0]  m1_memLen,
    input  logic        m1_signed,
    output logic [31:0] m1_dataIn,
    output logic        m1_ready,
    output logic        m1_err,

    output logic [31:0] s_addr,
    output logic [31:0] s_dataOut,
    output logic [1:0]  s_accessType,
    output logic [1:0]  s_memLen,
    output logic        s_signed,
    input  logic [31:0] s_dataIn,
    input  logic        s_ready,

    output logic [1:0]  owner
);

    // Access-type encoding; NONE means "no request"
    localparam logic [1:0] ACC_NONE = 2'b00;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACCESS = 1'b1;

    localparam bit WD_EN = (TIMEOUT != 0);
    // The counter holds the number of completed non-ready ACCESS cycles, so
    // the TIMEOUT-th non-ready cycle is the one where it equals TIMEOUT-1.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

    logic [0:0]       state_q, state_d;
    logic [1:0]       owner_q, owner_d;
    logic             last_q,  last_d;    // 1 = master 1 was granted last
    logic [31:0]      addr_q,  addr_d;
    logic [31:0]      wdat_q,  wdat_d;
    logic [1:0]       acc_q,   acc_d;
    logic [1:0]       len_q,   len_d;
    logic             sgn_q,   sgn_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;

    logic w_req0;
    logic w_req1;
    logic w_pick1;
    logic w_done;
    logic w_tmo;

    assign w_req0  = (m0_accessType != ACC_NONE);
    assign w_req1  = (m1_accessType != ACC_NONE);
    // Master 1 wins if it is the only requester, or on a tie when master 0 went last
    assign w_pick1 = w_req1 && (!w_req0 || !last_q);
    assign w_done  = (state_q == ST_ACCESS) && s_ready;
    // Ready in the timeout cycle takes priority, hence the !s_ready term
    assign w_tmo   = WD_EN && (state_q == ST_ACCESS) && !s_ready && (cnt_q == CNT_LAST);

    // State register: all arbiter state, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!res) begin
            state_q <= ST_IDLE;
            owner_q <= 2'b00;
            last_q  <= 1'b1;
            addr_q  <= '0;
            wdat_q  <= '0;
            acc_q   <= ACC_NONE;
            len_q   <= '0;
            sgn_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            wdat_q  <= wdat_d;
            acc_q   <= acc_d;
            len_q   <= len_d;
            sgn_q   <= sgn_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: grant in IDLE, complete or abort in ACCESS
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        addr_d  = addr_q;
        wdat_d  = wdat_q;
        acc_d   = acc_q;
        len_d   = len_q;
        sgn_d   = sgn_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (w_req0 || w_req1) begin
                    state_d = ST_ACCESS;
                    owner_d = w_pick1 ? 2'b10 : 2'b01;
                    last_d  = w_pick1;
                    cnt_d   = '0;
                    if (w_pick1) begin
                        addr_d = m1_addr;
                        wdat_d = m1_dataOut;
                        acc_d  = m1_accessType;
                        len_d  = m1_memLen;
                        sgn_d  = m1_signed;
                    end else begin
                        addr_d = m0_addr;
                        wdat_d = m0_dataOut;
                        acc_d  = m0_accessType;
                        len_d  = m0_memLen;
                        sgn_d  = m0_signed;
                    end
                end
            end
            ST_ACCESS: begin
                if (w_done || w_tmo) begin
                    state_d = ST_IDLE;
                    owner_d = 2'b00;
                    acc_d   = ACC_NONE;
                    cnt_d   = '0;
                end else if (WD_EN) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output logic: completion/abort pulses and read data routed to the owner only
    always_comb begin
        m0_ready  = res && w_done && owner_q[0];
        m1_ready  = res && w_done && owner_q[1];
        m0_err    = res && w_tmo  && owner_q[0];
        m1_err    = res && w_tmo  && owner_q[1];
        m0_dataIn = (res && w_done && owner_q[0]) ? s_dataIn : 32'h0;
        m1_dataIn = (res && w_done && owner_q[1]) ? s_dataIn : 32'h0;
    end

    assign s_addr       = addr_q;
    assign s_dataOut    = wdat_q;
    assign s_accessType = acc_q;
    assign s_memLen     = len_q;
    assign s_signed     = sgn_q;
    assign owner        = owner_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_mem_bus_arbiter
//  Description : Self-checking bench for mem_bus_arbiter. A transaction-level
//                model predicts every output each cycle; directed scenarios
//                add hand-computed literal expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_bus_arbiter;

    localparam int TO = 4;
    localparam logic [1:0] A_NONE = 2'd0, A_R = 2'd1, A_W = 2'd2, A_X = 2'd3;
    localparam logic [1:0] L_B = 2'd0, L_H = 2'd1, L_W = 2'd2;

    logic        clk = 1'b0;
    logic        res = 1'b0;
    logic [31:0] m0_addr, m0_dataOut, m1_addr, m1_dataOut;
    logic [1:0]  m0_accessType, m0_memLen, m1_accessType, m1_memLen;
    logic        m0_signed, m1_signed;
    logic [31:0] m0_dataIn, m1_dataIn;
    logic        m0_ready, m0_err, m1_ready, m1_err;
    logic [31:0] s_addr, s_dataOut;
    logic [1:0]  s_accessType, s_memLen;
    logic        s_signed;
    logic [31:0] s_dataIn = 32'h0;
    logic        s_ready  = 1'b0;
    logic [1:0]  owner;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.TIMEOUT(TO), .CNT_W(8)) dut (
        .clk(clk), .res(res),
        .m0_addr(m0_addr), .m0_dataOut(m0_dataOut), .m0_accessType(m0_accessType),
        .m0_memLen(m0_memLen), .m0_signed(m0_signed), .m0_dataIn(m0_dataIn),
        .m0_ready(m0_ready), .m0_err(m0_err),
        .m1_addr(m1_addr), .m1_dataOut(m1_dataOut), .m1_accessType(m1_accessType),
        .m1_memLen(m1_memLen), .m1_signed(m1_signed), .m1_dataIn(m1_dataIn),
        .m1_ready(m1_ready), .m1_err(m1_err),
        .s_addr(s_addr), .s_dataOut(s_dataOut), .s_accessType(s_accessType),
        .s_memLen(s_memLen), .s_signed(s_signed), .s_dataIn(s_dataIn),
        .s_ready(s_ready), .owner(owner)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%h expected=%h @%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- slave responder ----------------
    int          slv_delay = -1;   // ready on ACCESS cycle slv_delay+1; -1 = never
    logic [31:0] slv_rdata = 32'h0;
    logic        force_rdy = 1'b0;
    int          s_age     = 0;

    always @(posedge clk) begin
        #1;
        if (s_accessType != A_NONE) s_age = s_age + 1;
        else                        s_age = 0;
        s_ready  = force_rdy || (slv_delay >= 0 && s_age == slv_delay + 1);
        s_dataIn = slv_rdata;
    end

    // ---------------- grant log ----------------
    logic [1:0]  glog[$];
    logic [31:0] gdata[$];
    logic [1:0]  prev_owner = 2'b00;

    always @(posedge clk) begin
        #3;
        if (owner != prev_owner && owner != 2'b00) begin
            glog.push_back(owner);
            gdata.push_back(s_dataOut);
        end
        prev_owner = owner;
    end

    // ---------------- transaction-level model ----------------
    bit          chk_en = 1'b0;
    bit          m_busy = 1'b0;
    int          m_who  = 0;
    int          m_age  = 0;     // ACCESS cycles elapsed, 1 on the first
    int          m_last = 1;
    logic [31:0] m_addr = 32'h0, m_wdat = 32'h0;
    logic [1:0]  m_acc  = 2'b0, m_len = 2'b0;
    logic        m_sgn  = 1'b0;

    always @(negedge clk) begin : p_model
        logic       done, tmo, r0, r1;
        logic [1:0] e_owner;
        logic       e_rdy0, e_rdy1, e_err0, e_err1;
        int         win;
        done = m_busy && (res === 1'b1) && (s_ready === 1'b1);
        tmo  = m_busy && (res === 1'b1) && (s_ready === 1'b0) && (TO > 0) && (m_age == TO);
        if (chk_en) begin
            e_owner = !m_busy ? 2'b00 : ((m_who == 1) ? 2'b10 : 2'b01);
            e_rdy0  = done && (m_who == 0);
            e_rdy1  = done && (m_who == 1);
            e_err0  = tmo  && (m_who == 0);
            e_err1  = tmo  && (m_who == 1);
            chk("mdl_owner",   32'(owner),        32'(e_owner));
            chk("mdl_s_acc",   32'(s_accessType), 32'(m_busy ? m_acc : A_NONE));
            if (m_busy) begin
                chk("mdl_s_addr", s_addr,           m_addr);
                chk("mdl_s_wdat", s_dataOut,        m_wdat);
                chk("mdl_s_len",  32'(s_memLen),    32'(m_len));
                chk("mdl_s_sgn",  32'(s_signed),    32'(m_sgn));
            end
            chk("mdl_m0_rdy",  32'(m0_ready), 32'(e_rdy0));
            chk("mdl_m1_rdy",  32'(m1_ready), 32'(e_rdy1));
            chk("mdl_m0_err",  32'(m0_err),   32'(e_err0));
            chk("mdl_m1_err",  32'(m1_err),   32'(e_err1));
            chk("mdl_m0_data", m0_dataIn, e_rdy0 ? s_dataIn : 32'h0);
            chk("mdl_m1_data", m1_dataIn, e_rdy1 ? s_dataIn : 32'h0);
        end
        // advance the model to the state after the coming posedge
        if (res !== 1'b1) begin
            m_busy = 1'b0; m_last = 1; m_age = 0;
            m_addr = 32'h0; m_wdat = 32'h0; m_acc = A_NONE; m_len = 2'b0; m_sgn = 1'b0;
        end else if (m_busy) begin
            if (done || tmo) m_busy = 1'b0;
            else             m_age  = m_age + 1;
        end else begin
            r0 = (m0_accessType != A_NONE);
            r1 = (m1_accessType != A_NONE);
            if (r0 || r1) begin
                win    = (r0 && r1) ? (1 - m_last) : (r1 ? 1 : 0);
                m_busy = 1'b1; m_who = win; m_last = win; m_age = 1;
                if (win == 1) begin
                    m_addr = m1_addr; m_wdat = m1_dataOut; m_acc = m1_accessType;
                    m_len  = m1_memLen; m_sgn = m1_signed;
                end else begin
                    m_addr = m0_addr; m_wdat = m0_dataOut; m_acc = m0_accessType;
                    m_len  = m0_memLen; m_sgn = m0_signed;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic m0_req(input logic [1:0] a, input logic [31:0] ad, input logic [31:0] d,
                          input logic [1:0] l, input logic s);
        m0_accessType = a; m0_addr = ad; m0_dataOut = d; m0_memLen = l; m0_signed = s;
    endtask

    task automatic m1_req(input logic [1:0] a, input logic [31:0] ad, input logic [31:0] d,
                          input logic [1:0] l, input logic s);
        m1_accessType = a; m1_addr = ad; m1_dataOut = d; m1_memLen = l; m1_signed = s;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation time limit exceeded");
    end

    initial begin
        int err_at, rdy_at, errs;
        m0_req(A_NONE, 32'h0, 32'h0, L_B, 1'b0);
        m1_req(A_NONE, 32'h0, 32'h0, L_B, 1'b0);
        res = 1'b0;
        repeat (3) tick();
        chk_en = 1'b1;

        // reset state
        chk("rst_owner", 32'(owner), 32'h0);
        chk("rst_s_acc", 32'(s_accessType), 32'h0);
        chk("rst_s_addr", s_addr, 32'h0);
        chk("rst_s_wdat", s_dataOut, 32'h0);
        chk("rst_s_len", 32'(s_memLen), 32'h0);
        chk("rst_s_sgn", 32'(s_signed), 32'h0);
        chk("rst_m0_rdy", 32'(m0_ready), 32'h0);
        chk("rst_m1_err", 32'(m1_err), 32'h0);
        res = 1'b1;

        // s_ready while IDLE is ignored
        force_rdy = 1'b1;
        tick(); tick();
        chk("idle_srdy_m0_rdy", 32'(m0_ready), 32'h0);
        chk("idle_srdy_owner", 32'(owner), 32'h0);
        force_rdy = 1'b0;
        tick();

        // simultaneous requests, continuous: strict alternation starting with m0
        slv_delay = 3; slv_rdata = 32'h0BAD_F00D;
        m0_req(A_X, 32'h0, 32'h0, L_W, 1'b0);
        m1_req(A_W, 32'h2000, 32'h55AA, L_W, 1'b0);
        for (int i = 0; i < 80 && glog.size() < 4; i++) tick();
        for (int i = 0; i < 20 && owner != 2'b00; i++) tick();
        m0_req(A_NONE, 32'h0, 32'h0, L_B, 1'b0);
        m1_req(A_NONE, 32'h0, 32'h0, L_B, 1'b0);
        tick();
        chk("rr_grants", 32'(glog.size()), 32'd4);
        chk("rr_g0", 32'(glog[0]), 32'h1);
        chk("rr_g1", 32'(glog[1]), 32'h2);
        chk("rr_g2", 32'(glog[2]), 32'h1);
        chk("rr_g3", 32'(glog[3]), 32'h2);
        chk("rr_m1_wdata", gdata[1], 32'h55AA);
        tick();

        // single read, minimum slave latency + 1
        slv_delay = 1; slv_rdata = 32'hDEAD_BEEF;
        m0_req(A_R, 32'h1000, 32'h0, L_W, 1'b0);          // cycle t
        tick();                                            // t+1
        chk("rd_s_addr", s_addr, 32'h1000);
        chk("rd_s_acc", 32'(s_accessType), 32'(A_R));
        chk("rd_owner", 32'(owner), 32'h1);
        chk("rd_early_rdy", 32'(m0_ready), 32'h0);
        tick();                                            // t+2
        chk("rd_m0_rdy", 32'(m0_ready), 32'h1);
        chk("rd_m0_data", m0_dataIn, 32'hDEAD_BEEF);
        chk("rd_m1_data", m1_dataIn, 32'h0);
        m0_req(A_NONE, 32'h0, 32'h0, L_B, 1'b0);
        tick();                                            // t+3
        chk("rd_owner_after", 32'(owner), 32'h0);
        chk("rd_acc_after", 32'(s_accessType), 32'h0);
        chk("rd_data_after", m0_dataIn, 32'h0);

        // pending request from the non-owner
        slv_delay = 2; slv_rdata = 32'h1234_5678;
        m0_req(A_R, 32'h3000, 32'h0, L_H, 1'b1);
        tick();
        m1_req(A_R, 32'h4000, 32'h0, L_B, 1'b1);
        for (int i = 0; i < 20 && m0_ready !== 1'b1; i++) begin
            chk("pend_m1_held", 32'(m1_ready), 32'h0);
            tick();
        end
        chk("pend_m0_rdy", 32'(m0_ready), 32'h1);
        chk("pend_m0_data", m0_dataIn, 32'h1234_5678);
        m0_req(A_NONE, 32'h0, 32'h0, L_B, 1'b0);
        tick();
        chk("pend_idle_owner", 32'(owner), 32'h0);
        tick();
        chk("pend_m1_owner", 32'(owner), 32'h2);
        chk("pend_m1_addr", s_addr, 32'h4000);
        for (int i = 0; i < 20 && m1_ready !== 1'b1; i++) tick();
        chk("pend_m1_rdy", 32'(m1_ready), 32'h1);
        m1_req(A_NONE, 32'h0, 32'h0, L_B, 1'b0);
        tick();

        // watchdog abort
        slv_delay = -1;
        m1_req(A_R, 32'h5000, 32'h0, L_W, 1'b0);
        tick();                                            // ACCESS cycle 1
        err_at = 0;
        for (int i = 1; i <= 10; i++) begin
            if (m1_err === 1'b1) begin
                err_at = i;
                break;
            end
            tick();
        end
        chk("wd_err_cycle", 32'(err_at), 32'd4);
        m1_req(A_NONE, 32'h0, 32'h0, L_B, 1'b0);
        tick();
        chk("wd_acc_none", 32'(s_accessType), 32'h0);
        chk("wd_owner_none", 32'(owner), 32'h0);
        errs = 0;
        for (int i = 0; i < 4; i++) begin
            if (m1_err === 1'b1) errs++;
            tick();
        end
        chk("wd_single_pulse", 32'(errs), 32'h0);
        slv_delay = 0;
        m0_req(A_W, 32'h6000, 32'hCAFE, L_W, 1'b0);
        tick();
        chk("wd_next_owner", 32'(owner), 32'h1);
        chk("wd_next_rdy", 32'(m0_ready), 32'h1);
        m0_req(A_NONE, 32'h0, 32'h0, L_B, 1'b0);
        tick();

        // ready in the timeout cycle wins
        slv_delay = 3; slv_rdata = 32'hA5A5_A5A5;
        m0_req(A_R, 32'h7000, 32'h0, L_W, 1'b0);
        tick();
        rdy_at = 0; errs = 0;
        for (int i = 1; i <= 10; i++) begin
            if (m0_err === 1'b1) errs++;
            if (m0_ready === 1'b1) begin
                rdy_at = i;
                break;
            end
            tick();
        end
        chk("coin_rdy_cycle", 32'(rdy_at), 32'd4);
        chk("coin_err_count", 32'(errs), 32'h0);
        chk("coin_data", m0_dataIn, 32'hA5A5_A5A5);
        m0_req(A_NONE, 32'h0, 32'h0, L_B, 1'b0);
        tick();

        // reset mid-ACCESS; last grant was m0, reset must make m0 win the tie
        slv_delay = -1;
        m0_req(A_R, 32'h8000, 32'h0, L_W, 1'b0);
        tick(); tick();
        res = 1'b0;
        m1_req(A_R, 32'h9000, 32'h0, L_W, 1'b0);
        tick();
        chk("mr_owner", 32'(owner), 32'h0);
        chk("mr_s_acc", 32'(s_accessType), 32'h0);
        chk("mr_m0_rdy", 32'(m0_ready), 32'h0);
        chk("mr_m0_err", 32'(m0_err), 32'h0);
        res = 1'b1;
        slv_delay = 1; slv_rdata = 32'h0000_0042;
        tick();
        chk("mr_m0_wins", 32'(owner), 32'h1);
        chk("mr_m0_addr", s_addr, 32'h8000);
        for (int i = 0; i < 20 && m0_ready !== 1'b1; i++) tick();
        chk("mr_m0_rdy_after", 32'(m0_ready), 32'h1);
        m0_req(A_NONE, 32'h0, 32'h0, L_B, 1'b0);
        for (int i = 0; i < 20 && m1_ready !== 1'b1; i++) tick();
        chk("mr_m1_rdy_after", 32'(m1_ready), 32'h1);
        m1_req(A_NONE, 32'h0, 32'h0, L_B, 1'b0);
        tick(); tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire
